// File: rtl/hci_core_r_responder.sv
// hci_core_r_responder: target-side end of the HCI core protocol.
// Accepts requests against a credit budget, drives a fixed-latency SRAM-style
// memory port and returns in-order responses through a bypassable FIFO.
// Optional feature: define HCI_CORE_RESPONDER_ERR_EN to reject addresses
// >= MEM_SIZE (no memory access, response flagged with r_opc_o=1).
module hci_core_r_responder #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned UW          = 1,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter bit          WRITE_RESP  = 1'b1,
  parameter int unsigned MEM_SIZE    = 4096
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   add_i,
  input  logic            we_n_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [UW-1:0]   user_i,
  input  logic            lrdy_i,
  output logic            r_valid_o,
  output logic [DW-1:0]   r_data_o,
  output logic            r_opc_o,
  output logic [UW-1:0]   r_user_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_add_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Reject nonsensical configurations at elaboration time.
  if (MEM_LATENCY < 1 || FIFO_DEPTH < 1 || UW < 1 || MEM_SIZE < 1) begin : g_param_check
    $fatal(1, "hci_core_r_responder: invalid parameter set");
  end

  typedef struct packed {
    logic          vld;
    logic          we_n;
    logic [UW-1:0] user;
    logic          opc;
  } pipe_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          opc;
    logic [UW-1:0] user;
  } resp_t;

  pipe_t         r_pipe [MEM_LATENCY];
  resp_t         r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_cnt;

  logic  w_accept, w_err, w_resp_in;
  logic  w_fifo_empty, w_fifo_full, w_bypass, w_push, w_pop, w_hs;
  pipe_t w_tail;
  resp_t w_tail_resp;

`ifdef HCI_CORE_RESPONDER_ERR_EN
  assign w_err = ({1'b0, add_i} >= (AW + 1)'(MEM_SIZE));
`else
  assign w_err = 1'b0;
`endif

  // Grant is a function of registered credit state and the flush only.
  assign gnt_o     = ~clear_i & (r_cnt < CW'(FIFO_DEPTH));
  assign w_accept  = req_i & gnt_o;
  assign w_resp_in = w_accept & (we_n_i | WRITE_RESP);

  assign mem_req_o   = w_accept & ~w_err;
  assign mem_we_o    = ~we_n_i;
  assign mem_add_o   = add_i;
  assign mem_wdata_o = data_i;
  assign mem_be_o    = be_i;

  // Tail of the latency pipeline lines up with mem_rdata_i.
  assign w_tail      = r_pipe[MEM_LATENCY-1];
  assign w_tail_resp = '{data: (w_tail.we_n & ~w_tail.opc) ? mem_rdata_i : '0,
                         opc:  w_tail.opc,
                         user: w_tail.user};

  assign w_fifo_empty = (r_fill == '0);
  assign w_fifo_full  = (r_fill == CW'(FIFO_DEPTH));
  assign w_bypass     = w_tail.vld & w_fifo_empty & lrdy_i;
  assign w_push       = w_tail.vld & ~w_bypass;
  assign w_pop        = ~w_fifo_empty & lrdy_i;
  assign r_valid_o    = ~w_fifo_empty | w_bypass;
  assign w_hs         = r_valid_o & lrdy_i;

  // Response output mux: FIFO head has priority, bypass only when FIFO empty.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    r_data_o = '0;
    r_opc_o  = 1'b0;
    r_user_o = '0;
    if (!w_fifo_empty) begin
      r_data_o = r_fifo[r_rptr].data;
      r_opc_o  = r_fifo[r_rptr].opc;
      r_user_o = r_fifo[r_rptr].user;
    end else if (w_bypass) begin
      r_data_o = w_tail_resp.data;
      r_opc_o  = w_tail_resp.opc;
      r_user_o = w_tail_resp.user;
    end
  end

  // Latency pipeline carrying response metadata alongside the memory access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge value.
    if (!rst_ni) begin
      for (int i = 0; i < MEM_LATENCY; i++) r_pipe[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < MEM_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{vld: w_resp_in, we_n: we_n_i, user: user_i, opc: w_err};
      for (int i = 1; i < MEM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // FIFO control: pointers and fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // FIFO payload storage, written on push.
  always_ff @(posedge clk_i) begin
    // NOTE: payload is not reset; the fill count alone decides what is valid.
    if (w_push) r_fifo[r_wptr] <= w_tail_resp;
  end

  // Credit counter: responses owed to the initiator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_resp_in, w_hs})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // The credit bound keeps the FIFO from ever being full while data arrives.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_fifo_full && w_tail.vld));

endmodule

// File: tb/tb_hci_core_r_responder.sv
// Bench for hci_core_r_responder: scripted table, hand sequences for the
// multi-cycle corners, and randomized traffic checked against a queue model.
module tb_hci_core_r_responder;

  localparam int ML = 2;
  localparam int FD = 3;
  localparam int MS = 4096;
  localparam bit WR = 1'b1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] add_i;
  logic        we_n_i;
  logic [31:0] data_i;
  logic [3:0]  be_i;
  logic [0:0]  user_i;
  logic        lrdy_i;
  logic        r_valid_o;
  logic [31:0] r_data_o;
  logic        r_opc_o;
  logic [0:0]  r_user_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_add_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  hci_core_r_responder #(
    .AW(32), .DW(32), .UW(1), .MEM_LATENCY(ML), .FIFO_DEPTH(FD),
    .WRITE_RESP(WR), .MEM_SIZE(MS)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .we_n_i(we_n_i),
    .data_i(data_i), .be_i(be_i), .user_i(user_i), .lrdy_i(lrdy_i),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_opc_o(r_opc_o), .r_user_o(r_user_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_add_o(mem_add_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory device: 64 words, reads return after ML cycles, junk otherwise.
  logic [31:0] dev_mem [64];
  logic [31:0] rd_pipe [ML];
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= 32'hA0 + 32'(4 * i);
    end else if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) dev_mem[mem_add_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
    rd_pipe[0] <= (mem_req_o && !mem_we_o) ? dev_mem[mem_add_o[7:2]] : $urandom();
    for (int k = 1; k < ML; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata_i = rd_pipe[ML-1];

  // Reference model: owed responses in order, each with the cycle it surfaces.
  typedef struct {
    int          rdy;
    logic [31:0] data;
    logic        user;
    logic        opc;
  } exp_t;

  typedef struct {
    logic        gnt;
    logic        mem_req;
    logic        rv;
    logic [31:0] rdata;
    logic        ruser;
    logic        ropc;
  } obs_t;

  typedef struct {
    logic        req;
    logic        we_n;
    logic [31:0] add;
    logic        lrdy;
    logic        gnt;
    logic        mreq;
    logic        rv;
    logic [31:0] rdata;
  } vec_t;

  exp_t        q[$];
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, compare with the model, advance.
  task automatic step(input logic req, input logic we_n, input logic [31:0] add,
                      input logic [31:0] data, input logic [3:0] be, input logic user,
                      input logic lrdy, input logic clr, output obs_t o);
    logic exp_gnt, acc, err, exp_mreq, exp_rv;
    exp_t h, n;
    req_i = req; we_n_i = we_n; add_i = add; data_i = data; be_i = be;
    user_i = user; lrdy_i = lrdy; clear_i = clr;
    #5;
    o.gnt = gnt_o; o.mem_req = mem_req_o; o.rv = r_valid_o;
    o.rdata = r_data_o; o.ruser = r_user_o; o.ropc = r_opc_o;
    exp_gnt = !clr && (q.size() < FD);
    acc = req && exp_gnt;
`ifdef HCI_CORE_RESPONDER_ERR_EN
    err = (add >= MS);
`else
    err = 1'b0;
`endif
    exp_mreq = acc && !err;
    check("gnt", gnt_o, exp_gnt);
    check("mem_req", mem_req_o, exp_mreq);
    if (exp_mreq) begin
      check("mem_we", mem_we_o, !we_n);
      check("mem_add", mem_add_o, add);
      check("mem_wdata", mem_wdata_o, data);
      check("mem_be", mem_be_o, be);
    end
    exp_rv = 1'b0;
    h = '{rdy: 0, data: 32'h0, user: 1'b0, opc: 1'b0};
    if (q.size() > 0) begin
      h = q[0];
      if (h.rdy < cyc) exp_rv = 1'b1;
      else if (h.rdy == cyc) exp_rv = lrdy;
    end
    check("r_valid", r_valid_o, exp_rv);
    if (exp_rv) begin
      check("r_data", r_data_o, h.data);
      check("r_user", r_user_o, h.user);
      check("r_opc", r_opc_o, h.opc);
    end else begin
      check("r_idle_zero", {r_data_o, r_user_o, r_opc_o} == '0, 1'b1);
    end
    if (exp_rv && lrdy) void'(q.pop_front());
    if (acc && (we_n || WR)) begin
      n.rdy  = cyc + ML;
      n.data = (we_n && !err) ? ref_mem[add[7:2]] : 32'h0;
      n.user = user;
      n.opc  = err;
      q.push_back(n);
    end
    if (acc && !we_n && !err)
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[add[7:2]][8*b +: 8] = data[8*b +: 8];
    if (clr) q.delete();
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic lrdy, output obs_t o);
    step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, lrdy, 1'b0, o);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; clear_i = 1'b0; req_i = 1'b0; we_n_i = 1'b1; add_i = '0;
    data_i = '0; be_i = '0; user_i = '0; lrdy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    q.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA0 + 32'(4 * i);
    check("rst gnt", gnt_o, 1'b1);
    check("rst r_valid", r_valid_o, 1'b0);
    check("rst r_data", r_data_o, 32'h0);
    check("rst r_opc", r_opc_o, 1'b0);
    check("rst r_user", r_user_o, 1'b0);
    check("rst mem_req", mem_req_o, 1'b0);
    rst_ni = 1'b1;
  endtask

  initial begin
    vec_t tbl[15];
    obs_t o;
    obs_t os[4];
    logic [31:0] a;

    // Scripted from reset: back-to-back reads, then back-pressure filling credits.
    tbl[0]  = '{1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA4};
    tbl[4]  = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA8};
    tbl[5]  = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0};
    tbl[10] = '{1'b1, 1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0};
    tbl[11] = '{1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA4};
    tbl[12] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA8};
    tbl[13] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hAC};
    tbl[14] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    do_reset();

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req, tbl[i].we_n, tbl[i].add, 32'h0, 4'hF, 1'b0, tbl[i].lrdy, 1'b0, o);
      check($sformatf("tbl[%0d] gnt", i), o.gnt, tbl[i].gnt);
      check($sformatf("tbl[%0d] mem_req", i), o.mem_req, tbl[i].mreq);
      check($sformatf("tbl[%0d] r_valid", i), o.rv, tbl[i].rv);
      check($sformatf("tbl[%0d] r_data", i), o.rdata, tbl[i].rdata);
    end

    // Write with response, then read back the written word.
    step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0, os[0]);
    for (int i = 1; i <= ML; i++) idle(1'b1, os[i]);
    check("wr resp valid", os[ML].rv, 1'b1);
    check("wr resp data", os[ML].rdata, 32'h0);
    check("wr resp user", os[ML].ruser, 1'b1);
    step(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, os[0]);
    for (int i = 1; i <= ML; i++) idle(1'b1, os[i]);
    check("rd after wr", os[ML].rdata, 32'hDEADBEEF);

    // Flush with two reads in flight.
    step(1'b1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, o);
    step(1'b1, 1'b1, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, o);
    step(1'b1, 1'b1, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, o);
    check("clear gnt", o.gnt, 1'b0);
    check("clear mem_req", o.mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, o);
      check("post-clear r_valid", o.rv, 1'b0);
    end
    step(1'b1, 1'b1, 32'h8, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, os[0]);
    for (int i = 1; i <= ML; i++) idle(1'b1, os[i]);
    check("post-clear latency", os[ML].rv, 1'b1);
    check("post-clear data", os[ML].rdata, 32'hA8);
    check("post-clear user", os[ML].ruser, 1'b1);

`ifdef HCI_CORE_RESPONDER_ERR_EN
    // Out-of-range read is granted but never reaches memory.
    step(1'b1, 1'b1, 32'h1000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, os[0]);
    check("err gnt", os[0].gnt, 1'b1);
    check("err mem_req", os[0].mem_req, 1'b0);
    for (int i = 1; i <= ML; i++) idle(1'b1, os[i]);
    check("err r_valid", os[ML].rv, 1'b1);
    check("err r_opc", os[ML].ropc, 1'b1);
    check("err r_data", os[ML].rdata, 32'h0);
    step(1'b1, 1'b1, 32'hFFC, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, os[0]);
    for (int i = 1; i <= ML; i++) idle(1'b1, os[i]);
    check("last word r_opc", os[ML].ropc, 1'b0);
    check("last word r_data", os[ML].rdata, 32'h19C);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, a, $urandom(),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0, o);
    end

    // Reset in the middle of pending responses.
    step(1'b1, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, o);
    step(1'b1, 1'b1, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, o);
    idle(1'b0, o);
    idle(1'b0, o);
    rst_ni = 1'b0;
    req_i  = 1'b0;
    #1;
    check("async rst r_valid", r_valid_o, 1'b0);
    check("async rst gnt", gnt_o, 1'b1);
    do_reset();
    step(1'b1, 1'b1, 32'hC, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, os[0]);
    for (int i = 1; i <= ML; i++) idle(1'b1, os[i]);
    check("post-reset data", os[ML].rdata, 32'hAC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
